// File: rtl/mem_arb_pkg.sv
// ============================================================================
// mem_arb_pkg : shared types and default sizes for the two-port memory arbiter
// Revision    : 1.0
// ============================================================================
`default_nettype none

package mem_arb_pkg;

   localparam int unsigned DEF_DEPTH  = 256;
   localparam int unsigned DEF_ADDR_W = 32;
   localparam int unsigned DEF_DATA_W = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OWN0 = 2'd1,
      OWN1 = 2'd2
   } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/rr_pick2.sv
// ============================================================================
// rr_pick2 : 2-way round-robin picker; on contention the port != last wins
// Revision : 1.0
// ============================================================================
`default_nettype none

module rr_pick2 (
   input  logic [1:0] req,
   input  logic       last,
   output logic [1:0] gnt
);

   always_comb begin
      gnt = req;
      if (req == 2'b11) begin
         gnt = last ? 2'b01 : 2'b10;
      end
   end

endmodule

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ============================================================================
// mem_arbiter : round-robin arbiter/sequencer sharing one single-port memory
//               between two requesters, with optional lock for RMW sequences.
//               Optional out-of-range check: define MEM_ARB_ADDR_CHECK_EN.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned DEPTH  = DEF_DEPTH,
   parameter int unsigned ADDR_W = DEF_ADDR_W,
   parameter int unsigned DATA_W = DEF_DATA_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [1:0]        req,
   input  logic [1:0]        wr,
   input  logic [1:0]        lock,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata0,
   input  logic [DATA_W-1:0] wdata1,
   output logic [1:0]        gnt,
   output logic [1:0]        rvalid,
   output logic [DATA_W-1:0] rdata,
   output logic              rerr,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_din,
   output logic              mem_we,
   output logic              mem_re,
   input  logic [DATA_W-1:0] mem_out
);

`ifdef MEM_ARB_ADDR_CHECK_EN
   localparam bit CHECK_EN = 1'b1;
`else
   localparam bit CHECK_EN = 1'b0;
`endif

   arb_state_t        state;
   logic              last;
   logic [ADDR_W-1:0] hold_addr;
   logic [DATA_W-1:0] hold_din;

   logic [1:0]        pick;
   logic [1:0]        gnt_w;
   logic              any;
   logic              sel;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;
   logic              sel_wr;
   logic              sel_lock;
   logic              addr_ok;

   rr_pick2 u_pick (
      .req  (req),
      .last (last),
      .gnt  (pick)
   );

   // Grant is gated by rst_n so every output drops the moment reset asserts.
   always_comb begin
      gnt_w = 2'b00;
      case (state)
         IDLE:    gnt_w = pick;
         OWN0:    gnt_w = {1'b0, req[0]};
         OWN1:    gnt_w = {req[1], 1'b0};
         default: gnt_w = 2'b00;
      endcase
      if (!rst_n) begin
         gnt_w = 2'b00;
      end
   end

   assign gnt       = gnt_w;
   assign any       = |gnt_w;
   assign sel       = gnt_w[1];
   assign sel_addr  = sel ? addr1  : addr0;
   assign sel_wdata = sel ? wdata1 : wdata0;
   assign sel_wr    = sel ? wr[1]   : wr[0];
   assign sel_lock  = sel ? lock[1] : lock[0];
   assign addr_ok   = !CHECK_EN || (sel_addr < ADDR_W'(DEPTH));

   // Idle bus keeps presenting the last granted address/data.
   assign mem_addr = any ? sel_addr  : hold_addr;
   assign mem_din  = any ? sel_wdata : hold_din;
   assign mem_we   = any &  sel_wr & addr_ok;
   assign mem_re   = any & ~sel_wr & addr_ok;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         last      <= 1'b1;
         hold_addr <= '0;
         hold_din  <= '0;
         rvalid    <= 2'b00;
         rdata     <= '0;
         rerr      <= 1'b0;
      end else begin
         rvalid <= (any && !sel_wr) ? gnt_w : 2'b00;
         rerr   <= any & ~sel_wr & ~addr_ok;
         if (any) begin
            hold_addr <= sel_addr;
            hold_din  <= sel_wdata;
            last      <= sel;
            if (sel_lock) begin
               state <= sel ? OWN1 : OWN0;
            end else begin
               state <= IDLE;
            end
            if (!sel_wr) begin
               rdata <= addr_ok ? mem_out : '0;
            end
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ============================================================================
// tb_mem_arbiter : directed + random checks of mem_arbiter against a
//                  transaction-level model of ownership, fairness and memory.
// Revision       : 1.0
// ============================================================================
`default_nettype none

module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [1:0]  req, wr, lock;
   logic [31:0] addr0, addr1, wdata0, wdata1;
   logic [1:0]  gnt, rvalid;
   logic [31:0] rdata;
   logic        rerr;
   logic [31:0] mem_addr, mem_din;
   logic        mem_we, mem_re;
   logic [31:0] mem_out;

   mem_arbiter dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .req      (req),
      .wr       (wr),
      .lock     (lock),
      .addr0    (addr0),
      .addr1    (addr1),
      .wdata0   (wdata0),
      .wdata1   (wdata1),
      .gnt      (gnt),
      .rvalid   (rvalid),
      .rdata    (rdata),
      .rerr     (rerr),
      .mem_addr (mem_addr),
      .mem_din  (mem_din),
      .mem_we   (mem_we),
      .mem_re   (mem_re),
      .mem_out  (mem_out)
   );

   always #5 clk = ~clk;

   // Attached 256x32 memory; preloaded on the first edge (held in reset).
   logic [31:0] mem [0:255];
   bit          preloaded = 1'b0;
   always @(posedge clk) begin
      if (!preloaded) begin
         for (int k = 0; k < 256; k++) mem[k] <= 32'd0;
         mem[3]    <= 32'd17;
         mem[7]    <= 32'd5;
         mem[18]   <= 32'd99;
         preloaded <= 1'b1;
      end else if (mem_we && mem_addr < 32'd256) begin
         mem[mem_addr[7:0]] <= mem_din;
      end
   end
   assign mem_out = (mem_addr < 32'd256) ? mem[mem_addr[7:0]] : 32'd0;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state
   logic [31:0] ref_mem [0:255];
   int          owner;
   int          last_p;
   int          g_model;
   logic [1:0]  obs_gnt;
   logic [1:0]  pend_v;
   logic [31:0] pend_d;
   logic        pend_e;
   logic [31:0] hold_a, hold_d;

   function automatic bit addr_in_check(input logic [31:0] a);
`ifdef MEM_ARB_ADDR_CHECK_EN
      return a < 32'd256;
`else
      return 1'b1;
`endif
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      owner  = -1;
      last_p = 1;
      pend_v = 2'b00;
      pend_d = 32'd0;
      pend_e = 1'b0;
      hold_a = 32'd0;
      hold_d = 32'd0;
   endtask

   // One clock cycle: check mid-cycle against the model, then advance it.
   task automatic cycle();
      int          g;
      logic [31:0] a, d;
      bit          w, ok;
      @(negedge clk);
      g = -1;
      if (owner < 0) begin
         if (req == 2'b11)      g = (last_p == 0) ? 1 : 0;
         else if (req == 2'b01) g = 0;
         else if (req == 2'b10) g = 1;
      end else if (req[owner]) begin
         g = owner;
      end
      if (g >= 0) begin
         a = (g == 1) ? addr1  : addr0;
         d = (g == 1) ? wdata1 : wdata0;
         w = (g == 1) ? wr[1]  : wr[0];
      end else begin
         a = hold_a;
         d = hold_d;
         w = 1'b0;
      end
      ok      = (g >= 0) && addr_in_check(a);
      obs_gnt = gnt;
      chk("gnt",      gnt,      (g < 0) ? 32'd0 : (32'd1 << g));
      chk("mem_we",   mem_we,   (ok && w)  ? 32'd1 : 32'd0);
      chk("mem_re",   mem_re,   (ok && !w) ? 32'd1 : 32'd0);
      chk("mem_addr", mem_addr, a);
      chk("mem_din",  mem_din,  d);
      chk("rvalid",   rvalid,   pend_v);
      chk("rerr",     rerr,     pend_e);
      if (pend_v != 2'b00) chk("rdata", rdata, pend_d);
      pend_v = 2'b00;
      pend_e = 1'b0;
      if (g >= 0) begin
         last_p = g;
         owner  = lock[g] ? g : -1;
         hold_a = a;
         hold_d = d;
         if (!w) begin
            pend_v = 2'(1 << g);
            pend_d = (ok && a < 32'd256) ? ref_mem[a[7:0]] : 32'd0;
            pend_e = !addr_in_check(a);
         end else if (ok && a < 32'd256) begin
            ref_mem[a[7:0]] = d;
         end
      end
      g_model = g;
      @(posedge clk);
      #1;
   endtask

   initial begin
      for (int k = 0; k < 256; k++) ref_mem[k] = 32'd0;
      ref_mem[3]  = 32'd17;
      ref_mem[7]  = 32'd5;
      ref_mem[18] = 32'd99;
      req = 2'b00; wr = 2'b00; lock = 2'b00;
      addr0 = 32'd0; addr1 = 32'd0; wdata0 = 32'd0; wdata1 = 32'd0;
      rst_n = 1'b0;
      model_reset();

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_gnt",    gnt,    32'd0);
      chk("rst_rvalid", rvalid, 32'd0);
      chk("rst_rdata",  rdata,  32'd0);
      chk("rst_rerr",   rerr,   32'd0);
      chk("rst_we",     mem_we, 32'd0);
      chk("rst_re",     mem_re, 32'd0);
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Contention: both read, held 4 cycles -> 0,1,0,1
      req = 2'b11; wr = 2'b00; addr0 = 32'd3; addr1 = 32'd18;
      for (int k = 0; k < 4; k++) begin
         cycle();
         chk("cont_order", obs_gnt, (k % 2 == 0) ? 32'd1 : 32'd2);
      end
      req = 2'b00;
      cycle();

      // Single read port 0, addr 7
      req = 2'b01; addr0 = 32'd7;
      cycle();
      req = 2'b00;
      cycle();

      // Write then read-after-write on port 1
      req = 2'b10; wr = 2'b10; addr1 = 32'd3; wdata1 = 32'd42;
      cycle();
      wr = 2'b00;
      cycle();
      req = 2'b00;
      cycle();

      // Make port 0 the last winner so port 1 takes the locked sequence
      req = 2'b01; addr0 = 32'd7;
      cycle();
      req = 2'b11; addr0 = 32'd7; addr1 = 32'd18; lock = 2'b10; wr = 2'b00;
      cycle();
      chk("lock_g1", obs_gnt, 32'd2);
      lock = 2'b00; wr = 2'b10; wdata1 = 32'd7;
      cycle();
      chk("lock_g2", obs_gnt, 32'd2);
      req = 2'b01; wr = 2'b00;
      cycle();
      chk("lock_g3", obs_gnt, 32'd1);
      chk("lock_mem18", mem[18], 32'd7);
      req = 2'b01; addr0 = 32'd18;
      cycle();
      req = 2'b00;
      cycle();

      // Out-of-range read
      req = 2'b01; addr0 = 32'd300;
      cycle();
      req = 2'b00;
      cycle();

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         for (int p = 0; p < 2; p++) begin
            if (!req[p] && $urandom_range(0, 2) == 0) begin
               req[p]  = 1'b1;
               wr[p]   = 1'($urandom_range(0, 1));
               lock[p] = ($urandom_range(0, 3) == 0);
               if (p == 0) begin
                  addr0  = $urandom_range(0, 279);
                  wdata0 = $urandom;
               end else begin
                  addr1  = $urandom_range(0, 279);
                  wdata1 = $urandom;
               end
            end
         end
         cycle();
         if (g_model >= 0) req[g_model] = 1'b0;
      end

      // Mid-run reset with a locked read in flight
      req = 2'b01; wr = 2'b00; lock = 2'b01; addr0 = 32'd7;
      cycle();
      req = 2'b11; addr1 = 32'd18;
      #2 rst_n = 1'b0;
      #1;
      chk("mrst_gnt",    gnt,      32'd0);
      chk("mrst_rvalid", rvalid,   32'd0);
      chk("mrst_rdata",  rdata,    32'd0);
      chk("mrst_rerr",   rerr,     32'd0);
      chk("mrst_we",     mem_we,   32'd0);
      chk("mrst_re",     mem_re,   32'd0);
      chk("mrst_addr",   mem_addr, 32'd0);
      chk("mrst_din",    mem_din,  32'd0);
      @(posedge clk);
      #2 rst_n = 1'b1;
      model_reset();
      lock = 2'b00; addr0 = 32'd3;
      cycle();
      chk("mrst_first", obs_gnt, 32'd1);
      req = 2'b00;
      cycle();
      cycle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
